shift_register_sequenced: RTL and testbench
===========================================

// Module: shift_register_sequenced
// PURPOSE
//   Parametrised, bidirectional successor to the multiplier's left-shift register.
//   Loads a WORD_LENGTH operand, zero- or sign-extended, into a WORD-bit register.
//   Runs a counted burst of 1-bit shifts (left, logical right, arithmetic right) under a small FSM.
//   Pulses done when the burst ends.
//   Serves the multiplier datapath as both multiplicand (left) and multiplier/product (right) register.
// PARAMETERS
//   WORD_LENGTH  8                      operand width
//   WORD         2*WORD_LENGTH          register width
//   CNT_W        $clog2(WORD+1)         width of shiftCount / internal step counter
// PORTS
//   clk            in   1            rising-edge clock
//   reset          in   1            synchronous, active-low reset
//   load           in   1            load parallelInput (IDLE only)
//   signExtend     in   1            1: sign-extend on load; 0: zero-extend
//   parallelInput  in   WORD_LENGTH  operand to load
//   start          in   1            begin shift burst (IDLE only)
//   direction      in   1            0 = left, 1 = right; sampled with start
//   arithmetic     in   1            right shifts replicate MSB; sampled with start
//   shiftCount     in   CNT_W        number of 1-bit steps N; sampled with start
//   serialInput    in   1            fill bit for left / logical-right steps (live each step)
//   parallelOutput out  WORD         register contents
//   serialOutput   out  1            registered copy of the last bit shifted out
//   busy           out  1            1 while state != IDLE
//   done           out  1            1-cycle pulse at end of burst
// BEHAVIOUR
//   Reset (reset==0 at clk edge)
//     - register, serialOutput, done <= 0; state <= IDLE.
//     - Overrides everything, including mid-burst; no done pulse for an aborted burst.
//   FSM states: IDLE, SHIFT, DONE
//   IDLE
//     - load=1: register <= {{WORD_LENGTH{signExtend & parallelInput[MSB]}}, parallelInput}; stay IDLE.
//     - load=0, start=1: latch direction, arithmetic, cnt <= shiftCount.
//       -> SHIFT if shiftCount != 0; -> DONE if shiftCount == 0 (register unchanged).
//     - load and start together: load wins, start dropped.
//   SHIFT: one step per clk
//     - left:      reg <= {reg[WORD-2:0], serialInput}; serialOutput <= reg[WORD-1]
//     - right log: reg <= {serialInput, reg[WORD-1:1]}; serialOutput <= reg[0]
//     - right ari: reg <= {reg[WORD-1], reg[WORD-1:1]}; serialOutput <= reg[0]
//     - cnt <= cnt-1; if cnt==1 -> DONE.
//     - N > WORD is legal: exactly N steps are performed.
//   DONE
//     - done=1 for this cycle only, busy=1, register held; -> IDLE next edge.
//   Ignored inputs: load/start in SHIFT and DONE are ignored (not queued).
//   Timing
//     - start accepted at edge T; N shift edges T+1..T+N; done high in the cycle after edge T+N.
//     - Next start is accepted at edge T+N+2 at the earliest.
//   Output timing
//     - busy/done decode from state (registered).
//     - parallelOutput is the register itself; no combinational input-to-output paths.
// STRUCTURE
//   Package multiplier_pkg
//     - state enum {IDLE, SHIFT, DONE}
//     - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
//   Sub-module shift_step_counter
//     - Loadable CNT_W down-counter; flags last (cnt==1) and zero.
//   Top level: FSM plus the datapath register.
// TESTING (WORD_LENGTH=8)
//   1. Load B5, signExtend=1 -> FFB5; signExtend=0 -> 00B5; busy stays 0.
//   2. FFB5, start left N=4, serialInput=0 -> FB50.
//      done pulses exactly 5 cycles after start edge; serialOutput=1.
//   3. 8000, right arithmetic N=3 -> F000; 0003, right logical, serialInput=1, N=2 -> C000, serialOutput=1.
//   4. N=0 -> done on the cycle after start, register unchanged.
//      load+start together -> load only, no burst.
//   5. load/start asserted mid-burst ignored.
//      reset=0 at step 2 of an N=6 burst -> 0000 next edge, IDLE, no done pulse.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared types for the multiplier datapath: shifter FSM states and shift direction encoding.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step_counter.sv
// Loadable down-counter tracking the remaining 1-bit steps of a shift burst.
module shift_step_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loadEn,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             decEn,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (loadEn)
      count <= loadVal;
    else if (decEn && (count != '0))
      count <= count - 1'b1;
  end

  assign last = (count == CNT_W'(1));
  assign zero = (count == '0);

endmodule

// File: rtl/shift_register_sequenced.sv
// Bidirectional WORD-bit shift register with sign/zero-extending load and a counted,
// FSM-sequenced burst of 1-bit shifts that ends with a one-cycle done pulse.
module shift_register_sequenced
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int WORD        = 2 * WORD_LENGTH,
  parameter int CNT_W       = $clog2(WORD + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   signExtend,
  input  logic [WORD_LENGTH-1:0] parallelInput,
  input  logic                   start,
  input  logic                   direction,
  input  logic                   arithmetic,
  input  logic [CNT_W-1:0]       shiftCount,
  input  logic                   serialInput,
  output logic [WORD-1:0]        parallelOutput,
  output logic                   serialOutput,
  output logic                   busy,
  output logic                   done
);

  state_t          state;
  logic [WORD-1:0] shiftReg;
  logic            dirQ;
  logic            ariQ;
  logic            serialQ;
  logic            busyQ;
  logic            doneQ;

  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic             cntLast;
  logic             cntZero;
  logic             extBit;

  assign accept = (state == IDLE) && !load && start;
  assign extBit = signExtend & parallelInput[WORD_LENGTH-1];

  shift_step_counter #(.CNT_W(CNT_W)) uCnt (
    .clk     (clk),
    .reset   (reset),
    .loadEn  (accept),
    .loadVal (shiftCount),
    .decEn   (state == SHIFT),
    .count   (cnt),
    .last    (cntLast),
    .zero    (cntZero)
  );

  // busy/done are registered alongside the state transition so they never depend on inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      dirQ     <= DIR_LEFT;
      ariQ     <= 1'b0;
      serialQ  <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shiftReg <= {{(WORD - WORD_LENGTH){extBit}}, parallelInput};
          end else if (start) begin
            dirQ  <= direction;
            ariQ  <= arithmetic;
            busyQ <= 1'b1;
            if (shiftCount != '0) begin
              state <= SHIFT;
            end else begin
              state <= DONE;
              doneQ <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (dirQ == DIR_LEFT) begin
            shiftReg <= {shiftReg[WORD-2:0], serialInput};
            serialQ  <= shiftReg[WORD-1];
          end else begin
            shiftReg <= {(ariQ ? shiftReg[WORD-1] : serialInput), shiftReg[WORD-1:1]};
            serialQ  <= shiftReg[0];
          end
          // zero cannot occur here in normal flow; treat it as end-of-burst for robustness
          if (cntLast || cntZero) begin
            state <= DONE;
            doneQ <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busyQ <= 1'b0;
          doneQ <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busyQ <= 1'b0;
          doneQ <= 1'b0;
        end
      endcase
    end
  end

  assign parallelOutput = shiftReg;
  assign serialOutput   = serialQ;
  assign busy           = busyQ;
  assign done           = doneQ;

endmodule

// File: tb/tb_shift_register_sequenced.sv
// Directed plus randomized bench for shift_register_sequenced against an arithmetic reference model.
module tb_shift_register_sequenced;

  localparam int WL    = 8;
  localparam int W     = 2 * WL;
  localparam int CNT_W = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic             signExtend;
  logic [WL-1:0]    parallelInput;
  logic             start;
  logic             direction;
  logic             arithmetic;
  logic [CNT_W-1:0] shiftCount;
  logic             serialInput;
  logic [W-1:0]     parallelOutput;
  logic             serialOutput;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  // reference state
  int unsigned mReg;
  int unsigned mSo;

  shift_register_sequenced #(.WORD_LENGTH(WL)) dut (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .signExtend     (signExtend),
    .parallelInput  (parallelInput),
    .start          (start),
    .direction      (direction),
    .arithmetic     (arithmetic),
    .shiftCount     (shiftCount),
    .serialInput    (serialInput),
    .parallelOutput (parallelOutput),
    .serialOutput   (serialOutput),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input bit expBusy, input bit expDone);
    check({tag, ".reg"}, 32'(parallelOutput), mReg);
    check({tag, ".busy"}, 32'(busy), 32'(expBusy));
    check({tag, ".done"}, 32'(done), 32'(expDone));
  endtask

  task automatic doLoad(input logic [WL-1:0] v, input bit se);
    load = 1'b1; parallelInput = v; signExtend = se;
    tick();
    load = 1'b0;
    mReg = int'(v);
    if (se && v[WL-1]) mReg = mReg + 32'hFF00;
  endtask

  // Reference step: plain shifts/divides on an integer image of the register.
  task automatic modelStep(input bit dir, input bit ari, input bit s);
    if (!dir) begin
      mSo  = (mReg >> (W - 1)) & 1;
      mReg = ((mReg * 2) + s) % (1 << W);
    end else begin
      mSo  = mReg % 2;
      if (ari) mReg = (mReg / 2) + (mReg & (1 << (W - 1)));
      else     mReg = (mReg / 2) + (s << (W - 1));
    end
  endtask

  task automatic burst(input string tag, input bit dir, input bit ari, input int n,
                       input bit randSer, input bit fixedSer, input bit noise);
    bit s;
    start = 1'b1; direction = dir; arithmetic = ari; shiftCount = CNT_W'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, ".midDone"}, 32'(done), 32'd0);
      check({tag, ".midBusy"}, 32'(busy), 32'd1);
      s = randSer ? 1'($urandom) : fixedSer;
      serialInput = s;
      if (noise) begin
        load = 1'($urandom); start = 1'($urandom);
        parallelInput = WL'($urandom); signExtend = 1'($urandom);
      end
      tick();
      modelStep(dir, ari, s);
    end
    load = 1'b0; start = 1'b0;
    checkState({tag, ".end"}, 1'b1, 1'b1);
    if (n > 0) check({tag, ".so"}, 32'(serialOutput), mSo);
    tick();
    checkState({tag, ".idle"}, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; signExtend = 1'b0; parallelInput = '0; start = 1'b0;
    direction = 1'b0; arithmetic = 1'b0; shiftCount = '0; serialInput = 1'b0;
    mReg = 0; mSo = 0;
    tick(); tick();
    checkState("reset", 1'b0, 1'b0);
    check("reset.so", 32'(serialOutput), 32'd0);
    reset = 1'b1;

    // sign/zero extension on load
    doLoad(8'hB5, 1'b1);
    check("loadSext", 32'(parallelOutput), 32'h0000FFB5);
    check("loadSext.busy", 32'(busy), 32'd0);
    doLoad(8'hB5, 1'b0);
    check("loadZext", 32'(parallelOutput), 32'h000000B5);

    // left N=4 from FFB5
    doLoad(8'hB5, 1'b1);
    burst("left4", 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    check("left4.val", 32'(parallelOutput), 32'h0000FB50);
    check("left4.so", 32'(serialOutput), 32'd1);

    // build 8000 then arithmetic right 3
    doLoad(8'h80, 1'b0);
    burst("mk8000", 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    check("mk8000.val", 32'(parallelOutput), 32'h00008000);
    burst("ari3", 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    check("ari3.val", 32'(parallelOutput), 32'h0000F000);

    // logical right with fill 1
    doLoad(8'h03, 1'b0);
    burst("log2", 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    check("log2.val", 32'(parallelOutput), 32'h0000C000);
    check("log2.so", 32'(serialOutput), 32'd1);

    // N=0: done right after start, register unchanged
    burst("n0", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("n0.val", 32'(parallelOutput), 32'h0000C000);

    // load and start together: load wins
    load = 1'b1; start = 1'b1; parallelInput = 8'h5A; signExtend = 1'b0; shiftCount = CNT_W'(3);
    tick();
    load = 1'b0; start = 1'b0; mReg = 32'h5A;
    checkState("ldStart", 1'b0, 1'b0);
    tick();
    checkState("ldStart2", 1'b0, 1'b0);

    // load/start noise mid-burst is ignored
    doLoad(8'hC3, 1'b1);
    burst("noisy", 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1);

    // reset mid-burst aborts without a done pulse
    doLoad(8'h77, 1'b0);
    start = 1'b1; direction = 1'b0; arithmetic = 1'b0; shiftCount = CNT_W'(6);
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    mReg = 0;
    checkState("abort", 1'b0, 1'b0);
    check("abort.so", 32'(serialOutput), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort.noDone", 32'(done), 32'd0);
    end
    checkState("abort.idle", 1'b0, 1'b0);

    // randomized bursts, including N > WORD
    for (int k = 0; k < 25; k++) begin
      doLoad(WL'($urandom), 1'($urandom));
      burst("rand", 1'($urandom), 1'($urandom), int'($urandom_range(0, 20)),
            1'b1, 1'b0, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
